cl_msg_serializer: RTL and testbench

//  Downstream stage of the Camera Link capture block, in the bus_clk domain. Takes 128-bit

---
 rtl/cl_msg_serializer_pkg.sv | 28 ++
 rtl/cl_msg_serializer_if.sv | 28 ++
 rtl/cl_msg_serializer_msg_sync_fifo.sv | 55 +++++
 rtl/cl_msg_serializer.sv | 80 ++++++++
 tb/tb_cl_msg_serializer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cl_msg_serializer_pkg.sv
// Shared widths and message field layout for the Camera Link capture path.
// The capture block packs messages with these same offsets.
package cl_msg_serializer_pkg;

  localparam int MSG_W  = 128;
  localparam int WORD_W = 32;
  localparam int BEATS  = MSG_W / WORD_W;
  localparam int BEAT_W = $clog2(BEATS);

  localparam int LINE_FRAME_HI = 127;
  localparam int LINE_FRAME_LO = 96;
  localparam int CLK_COUNT_HI  = 89;
  localparam int CLK_COUNT_LO  = 80;
  localparam int DATA_HI       = 79;
  localparam int DATA_LO       = 0;

  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [MSG_W-1:0]  msg_t;
  typedef logic [WORD_W-1:0] word_t;

  // Word 0 is the most significant slice of the message.
  function automatic word_t msg_word(input msg_t msg, input beat_t beat);
    msg_t sh;
    sh = msg >> (WORD_W * (BEATS - 1 - int'(beat)));
    return sh[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/cl_msg_serializer_if.sv
// Message-in and PC write-FIFO signals of the serializer.
// slave is the serializer's view; master is the surrounding logic's view.
interface cl_msg_serializer_if;
  import cl_msg_serializer_pkg::*;

  msg_t  msg_in;
  logic  msg_in_valid;
  logic  pc_full;
  logic  pc_wren;
  word_t pc_data;

  modport master (
    output msg_in,
    output msg_in_valid,
    output pc_full,
    input  pc_wren,
    input  pc_data
  );

  modport slave (
    input  msg_in,
    input  msg_in_valid,
    input  pc_full,
    output pc_wren,
    output pc_data
  );

endinterface

// File: rtl/cl_msg_serializer_msg_sync_fifo.sv
// Single-clock message queue with first-word-fall-through head.
// Push while full is accepted only when a pop happens on the same edge.
module cl_msg_serializer_msg_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only entries behind the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/cl_msg_serializer.sv
// Queues capture messages and writes each as four MSB-first words to the PC FIFO.
// Messages arriving to a full queue are dropped, counted and flagged.
module cl_msg_serializer
  import cl_msg_serializer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                   i_bus_clk,
  input  logic                   i_reset,
  cl_msg_serializer_if.slave     bus,
  input  logic                   i_clear_overflow,
  output logic                   o_msg_overflow,
  output logic [DROP_W-1:0]      o_drop_count,
  output logic [$clog2(DEPTH):0] o_queue_count
);

  msg_t                   w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pc_wren;
  logic                   w_last_beat;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  beat_t                  r_beat;
  logic                   r_overflow;
  logic [DROP_W-1:0]      r_drop_count;

  assign w_pc_wren   = !w_empty && !bus.pc_full;
  assign w_last_beat = (r_beat == beat_t'(BEATS - 1));
  assign w_pop       = w_pc_wren && w_last_beat;
  assign w_push      = bus.msg_in_valid && (!w_full || w_pop);
  assign w_drop      = bus.msg_in_valid && w_full && !w_pop;

  cl_msg_serializer_msg_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MSG_W)
  ) u_fifo (
    .i_clk   (i_bus_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (bus.msg_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Beat only moves on an actual write, so a pc_full stall holds the current word.
  always_ff @(posedge i_bus_clk) begin
    if (i_reset) begin
      r_beat <= '0;
    end else if (w_pc_wren) begin
      r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
    end
  end

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge i_bus_clk) begin
    if (i_reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_drop)                r_overflow <= 1'b1;
      else if (i_clear_overflow) r_overflow <= 1'b0;
      if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign bus.pc_wren    = w_pc_wren;
  assign bus.pc_data    = msg_word(w_head, r_beat);
  assign o_msg_overflow = r_overflow;
  assign o_drop_count   = r_drop_count;
  assign o_queue_count  = w_count;

endmodule

// File: tb/tb_cl_msg_serializer.sv
// Scoreboard bench for cl_msg_serializer: stimulus queues expected words,
// a negedge monitor compares every PC FIFO write against them.
module tb_cl_msg_serializer;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        ovf;
  logic [15:0] dc;
  logic [2:0]  qc;

  int n_pass  = 0;
  int n_total = 0;
  int n_wr    = 0;
  logic [31:0] sbq[$];

  cl_msg_serializer_if ifc();

  cl_msg_serializer dut (
    .i_bus_clk        (clk),
    .i_reset          (rst),
    .bus              (ifc),
    .i_clear_overflow (clr),
    .o_msg_overflow   (ovf),
    .o_drop_count     (dc),
    .o_queue_count    (qc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_total=%0d", n_total);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (ifc.pc_wren === 1'b1) begin
      n_wr++;
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got pc_data %h expected no write", ifc.pc_data);
      end else begin
        logic [31:0] w;
        w = sbq.pop_front();
        chk("pc_data", 64'(ifc.pc_data), 64'(w));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_msg(input logic [127:0] m);
    sbq.push_back(m[127:96]);
    sbq.push_back(m[95:64]);
    sbq.push_back(m[63:32]);
    sbq.push_back(m[31:0]);
  endtask

  // Drives a one-cycle valid pulse; acc says whether the queue should take it.
  task automatic push(input logic [127:0] m, input bit acc);
    ifc.msg_in       = m;
    ifc.msg_in_valid = 1'b1;
    if (acc) exp_msg(m);
    cyc();
    ifc.msg_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int i;
    i = 0;
    while (i < max_cyc && (sbq.size() != 0 || ifc.pc_wren === 1'b1)) begin
      cyc();
      i++;
    end
    chk("drain_sb_empty", 64'(sbq.size()), 64'd0);
  endtask

  function automatic logic [127:0] mkmsg(input int k);
    logic [7:0] t;
    t = 8'(k + 'hA0);
    return {t, 24'h000011, t, 24'h000022, t, 24'h000033, t, 24'h000044};
  endfunction

  localparam logic [127:0] M1 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] M6 = 128'hDEAD0001_BEEF0002_CAFE0003_F00D0004;
  localparam logic [127:0] M7 = 128'h0A0B0C0D_1A1B1C1D_2A2B2C2D_3A3B3C3D;

  int n0;

  initial begin
    rst = 1'b1; clr = 1'b0;
    ifc.msg_in = '0; ifc.msg_in_valid = 1'b0; ifc.pc_full = 1'b0;
    repeat (3) cyc();
    #2;
    chk("rst_queue_count", 64'(qc), 64'd0);
    chk("rst_overflow", 64'(ovf), 64'd0);
    chk("rst_drop_count", 64'(dc), 64'd0);
    chk("rst_pc_wren", 64'(ifc.pc_wren), 64'd0);
    rst = 1'b0;
    cyc();

    // 1: single message, beat 0 one cycle after the push, four back-to-back words
    push(M1, 1'b1);
    #2 chk("t1_queue_count_after_push", 64'(qc), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pc_wren_beat", 64'(ifc.pc_wren), 64'd1);
      cyc();
      #2;
    end
    chk("t1_pc_wren_done", 64'(ifc.pc_wren), 64'd0);
    chk("t1_queue_count_done", 64'(qc), 64'd0);

    // 2: stall while beat 1 is presented
    n0 = n_wr;
    push(M1, 1'b1);
    cyc();
    ifc.pc_full = 1'b1;
    #2 chk("t2_stall_wren", 64'(ifc.pc_wren), 64'd0);
    chk("t2_stall_word", 64'(ifc.pc_data), 64'h33334444);
    repeat (4) cyc();
    ifc.pc_full = 1'b0;
    wait_drain(20);
    chk("t2_write_total", 64'(n_wr - n0), 64'd4);

    // 3: six messages into a stalled queue, last two dropped
    ifc.pc_full = 1'b1;
    for (int k = 0; k < 6; k++) push(mkmsg(k), k < 4);
    #2;
    chk("t3_queue_count", 64'(qc), 64'd4);
    chk("t3_overflow", 64'(ovf), 64'd1);
    chk("t3_drop_count", 64'(dc), 64'd2);
    n0 = n_wr;
    ifc.pc_full = 1'b0;
    wait_drain(40);
    chk("t3_write_total", 64'(n_wr - n0), 64'd16);
    chk("t3_queue_empty", 64'(qc), 64'd0);

    // 4: full queue, push on the beat-3 pop edge is accepted
    ifc.pc_full = 1'b1;
    for (int k = 8; k < 12; k++) push(mkmsg(k), 1'b1);
    #2 chk("t4_full", 64'(qc), 64'd4);
    ifc.pc_full = 1'b0;
    cyc(); cyc(); cyc();
    push(mkmsg(12), 1'b1);
    #2;
    chk("t4_queue_count_kept", 64'(qc), 64'd4);
    chk("t4_drop_unchanged", 64'(dc), 64'd2);
    wait_drain(60);

    // 5: clear vs drop priority, then saturation of the drop counter
    ifc.pc_full = 1'b1;
    for (int k = 16; k < 20; k++) push(mkmsg(k), 1'b1);
    clr = 1'b1;
    push(mkmsg(99), 1'b0);
    clr = 1'b0;
    #2;
    chk("t5_drop_wins", 64'(ovf), 64'd1);
    chk("t5_drop_count", 64'(dc), 64'd3);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    #2 chk("t5_clear", 64'(ovf), 64'd0);
    ifc.msg_in = mkmsg(98);
    ifc.msg_in_valid = 1'b1;
    repeat (65531) cyc();
    #2 chk("t5_drop_fffe", 64'(dc), 64'hFFFE);
    cyc();
    #2 chk("t5_drop_ffff", 64'(dc), 64'hFFFF);
    cyc();
    #2 chk("t5_drop_saturated", 64'(dc), 64'hFFFF);
    chk("t5_overflow_set", 64'(ovf), 64'd1);
    ifc.msg_in_valid = 1'b0;
    ifc.pc_full = 1'b0;
    wait_drain(40);

    // 6: reset while beat 2 is on the bus
    push(M6, 1'b1);
    cyc(); cyc();
    rst = 1'b1;
    #2 chk("t6_beat2_word", 64'(ifc.pc_data), 64'hCAFE0003);
    cyc();
    rst = 1'b0;
    #2;
    chk("t6_wren_after_rst", 64'(ifc.pc_wren), 64'd0);
    chk("t6_queue_after_rst", 64'(qc), 64'd0);
    chk("t6_overflow_after_rst", 64'(ovf), 64'd0);
    chk("t6_drop_after_rst", 64'(dc), 64'd0);
    chk("t6_abandoned_words", 64'(sbq.size()), 64'd1);
    sbq.delete();
    cyc();
    push(M7, 1'b1);
    #2 chk("t6_new_beat0", 64'(ifc.pc_data), 64'h0A0B0C0D);
    wait_drain(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
